// File: rtl/score_pkg.sv
// Shared state encodings and BCD constants for the score-display path.
package score_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_PLAY = 2'b01,
        ST_OVER = 2'b10
    } state_t;

    localparam logic [3:0] BCD_MAX = 4'd9;

endpackage

// File: rtl/bcd_digit_inc.sv
// Single BCD digit incrementer; chained per digit to form a multi-digit +1.
module bcd_digit_inc
    import score_pkg::*;
(
    input  logic [3:0] digit,
    input  logic       carry_in,
    output logic [3:0] digit_out,
    output logic       carry_out
);

    always_comb begin
        digit_out = digit;
        carry_out = 1'b0;
        if (carry_in && (digit == BCD_MAX)) begin
            digit_out = '0;
            carry_out = 1'b1;
        end else begin
            digit_out = digit + {3'b000, carry_in};
        end
    end

endmodule

// File: rtl/score_keeper.sv
// Game-state FSM that counts pipe passes as saturating BCD and keeps a session high score.
module score_keeper #(
    parameter int unsigned DIGITS = 2
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  start,
    input  logic                  pass,
    input  logic                  crash,
    output logic [1:0]            state,
    output logic [4*DIGITS-1:0]   score_bcd,
    output logic [4*DIGITS-1:0]   high_bcd,
    output logic                  score_tick,
    output logic                  new_high
);
    import score_pkg::*;

    state_t              fsm_state;
    logic                pass_q;
    logic                pass_edge;
    logic [DIGITS:0]     carry;
    logic [4*DIGITS-1:0] score_inc;
    logic                saturated;

    // Carry out of the top digit only occurs when every digit is 9.
    assign carry[0] = 1'b1;

    for (genvar i = 0; i < DIGITS; i++) begin : g_digit
        bcd_digit_inc u_digit (
            .digit     (score_bcd[4*i +: 4]),
            .carry_in  (carry[i]),
            .digit_out (score_inc[4*i +: 4]),
            .carry_out (carry[i+1])
        );
    end

    assign saturated = carry[DIGITS];
    assign pass_edge = pass & ~pass_q;
    assign state     = fsm_state;

    always_ff @(posedge clock) begin
        if (reset) begin
            fsm_state  <= ST_IDLE;
            pass_q     <= 1'b0;
            score_bcd  <= '0;
            high_bcd   <= '0;
            score_tick <= 1'b0;
            new_high   <= 1'b0;
        end else begin
            pass_q     <= pass;
            score_tick <= 1'b0;
            case (fsm_state)
                ST_IDLE, ST_OVER: begin
                    if (start) begin
                        fsm_state <= ST_PLAY;
                        score_bcd <= '0;
                        new_high  <= 1'b0;
                    end
                end
                ST_PLAY: begin
                    // Crash takes priority over a pass edge in the same cycle.
                    if (crash) begin
                        fsm_state <= ST_OVER;
                        if (score_bcd > high_bcd) begin
                            high_bcd <= score_bcd;
                            new_high <= 1'b1;
                        end
                    end else if (pass_edge && !saturated) begin
                        score_bcd  <= score_inc;
                        score_tick <= 1'b1;
                    end
                end
                default: fsm_state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_score_keeper.sv
// Directed bench for score_keeper: scoreboard of expected scores consumed on each score_tick.
module tb_score_keeper;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       start = 1'b0;
    logic       pass  = 1'b0;
    logic       crash = 1'b0;
    logic [1:0] state;
    logic [7:0] score_bcd;
    logic [7:0] high_bcd;
    logic       score_tick;
    logic       new_high;

    int checks     = 0;
    int errors     = 0;
    int tick_count = 0;
    int tick_base  = 0;

    logic [7:0] exp_q[$];
    logic [7:0] exp_score = 8'h00;
    logic [1:0] exp_state = 2'b00;

    score_keeper #(.DIGITS(2)) dut (
        .clock      (clock),
        .reset      (reset),
        .start      (start),
        .pass       (pass),
        .crash      (crash),
        .state      (state),
        .score_bcd  (score_bcd),
        .high_bcd   (high_bcd),
        .score_tick (score_tick),
        .new_high   (new_high)
    );

    always #5 clock = ~clock;

    // Reference increment: via binary, saturating at 99.
    function automatic logic [7:0] bcd_next(input logic [7:0] v);
        int unsigned b;
        b = v[7:4] * 10 + v[3:0];
        if (b < 99) b = b + 1;
        return {4'(b / 10), 4'(b % 10)};
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Called at a negedge with pass low; returns at a negedge.
    task automatic pass_pulse(input int unsigned hi, input int unsigned lo);
        pass = 1'b1;
        if (exp_state == 2'b01 && exp_score != 8'h99) begin
            exp_score = bcd_next(exp_score);
            exp_q.push_back(exp_score);
        end
        repeat (hi) @(negedge clock);
        pass = 1'b0;
        repeat (lo) @(negedge clock);
    endtask

    task automatic do_start();
        start = 1'b1;
        @(negedge clock);
        start = 1'b0;
        exp_state = 2'b01;
        exp_score = 8'h00;
    endtask

    task automatic do_crash();
        crash = 1'b1;
        @(negedge clock);
        crash = 1'b0;
        exp_state = 2'b10;
    endtask

    always @(negedge clock) begin
        if (score_tick === 1'b1) begin
            tick_count++;
            checks++;
            assert (exp_q.size() != 0) else begin
                errors++;
                $error("FAIL unexpected_tick: observed tick with score %0h expected no tick", score_bcd);
            end
            if (exp_q.size() != 0) begin
                logic [7:0] e;
                e = exp_q.pop_front();
                checks++;
                assert (score_bcd === e) else begin
                    errors++;
                    $error("FAIL tick_score: observed %0h expected %0h", score_bcd, e);
                end
            end
        end
    end

    initial begin
        repeat (2) @(negedge clock);
        check("rst_state", state, 2'b00);
        check("rst_score", score_bcd, 8'h00);
        check("rst_high", high_bcd, 8'h00);
        check("rst_tick", score_tick, 1'b0);
        check("rst_new_high", new_high, 1'b0);
        reset = 1'b0;
        @(negedge clock);

        do_start();
        check("start_state", state, 2'b01);
        tick_base = tick_count;
        repeat (12) pass_pulse(3, 2);
        check("score_12", score_bcd, 8'h12);
        check("ticks_12", tick_count - tick_base, 12);
        check("play_state", state, 2'b01);

        do_crash();
        check("over_state", state, 2'b10);
        check("over_high", high_bcd, 8'h12);
        check("over_new_high", new_high, 1'b1);
        pass_pulse(3, 2);
        check("over_pass_ignored", score_bcd, 8'h12);

        do_start();
        check("restart_new_high", new_high, 1'b0);
        check("restart_score", score_bcd, 8'h00);
        repeat (5) pass_pulse(1, 1);
        do_crash();
        check("low_game_high", high_bcd, 8'h12);
        check("low_game_new_high", new_high, 1'b0);
        check("low_game_score", score_bcd, 8'h05);

        do_start();
        tick_base = tick_count;
        pass_pulse(10, 2);
        check("long_pass_ticks", tick_count - tick_base, 1);
        check("long_pass_score", score_bcd, 8'h01);

        repeat (8) pass_pulse(1, 1);
        check("score_09", score_bcd, 8'h09);
        pass_pulse(1, 1);
        check("score_carry_10", score_bcd, 8'h10);
        while (exp_score != 8'h99) pass_pulse(1, 1);
        check("score_99", score_bcd, 8'h99);
        tick_base = tick_count;
        repeat (3) pass_pulse(1, 1);
        check("sat_score", score_bcd, 8'h99);
        check("sat_ticks", tick_count - tick_base, 0);

        do_crash();
        check("high_99", high_bcd, 8'h99);
        check("high_99_new_high", new_high, 1'b1);

        do_start();
        repeat (3) pass_pulse(1, 1);
        tick_base = tick_count;
        pass  = 1'b1;
        crash = 1'b1;
        exp_state = 2'b10;
        @(negedge clock);
        pass  = 1'b0;
        crash = 1'b0;
        @(negedge clock);
        check("crash_pass_score", score_bcd, 8'h03);
        check("crash_pass_state", state, 2'b10);
        check("crash_pass_ticks", tick_count - tick_base, 0);
        check("crash_pass_high", high_bcd, 8'h99);
        check("crash_pass_new_high", new_high, 1'b0);

        do_start();
        repeat (2) pass_pulse(1, 1);
        reset = 1'b1;
        @(negedge clock);
        check("mid_rst_state", state, 2'b00);
        check("mid_rst_score", score_bcd, 8'h00);
        check("mid_rst_high", high_bcd, 8'h00);
        check("mid_rst_tick", score_tick, 1'b0);
        check("mid_rst_new_high", new_high, 1'b0);
        reset = 1'b0;
        exp_state = 2'b00;
        exp_score = 8'h00;
        @(negedge clock);

        // pass already high when the game starts; start+crash together in IDLE starts.
        pass = 1'b1;
        @(negedge clock);
        start = 1'b1;
        crash = 1'b1;
        @(negedge clock);
        start = 1'b0;
        crash = 1'b0;
        exp_state = 2'b01;
        repeat (3) @(negedge clock);
        pass = 1'b0;
        @(negedge clock);
        check("held_pass_state", state, 2'b01);
        check("held_pass_score", score_bcd, 8'h00);
        pass_pulse(2, 1);
        check("after_held_score", score_bcd, 8'h01);

        @(negedge clock);
        check("queue_drained", exp_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
